// File: rtl/ser_rx_fifo_pkg.sv
// Shared definitions for the serial receive/transmit blocks: FSM encodings,
// line/idle constants and bit-timer reload helpers.
package ser_rx_fifo_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_e;

    localparam logic        LINE_IDLE  = 1'b1;
    localparam logic [7:0]  EMPTY_BYTE = 8'h00;
    localparam logic [15:0] CNT_ZERO   = 16'd0;
    localparam logic [15:0] CNT_ONE    = 16'd1;

    // Counters run down to zero inclusive, so each reload is one less than the
    // wanted interval; this keeps samples at exactly half a bit + n*bit_len.
    function automatic logic [15:0] half_bit_reload(input logic [15:0] bit_len);
        return (bit_len >> 1) - CNT_ONE;
    endfunction

    function automatic logic [15:0] full_bit_reload(input logic [15:0] bit_len);
        return bit_len - CNT_ONE;
    endfunction

endpackage

// File: rtl/ser_fifo.sv
// Synchronous byte FIFO with show-ahead read; the head reads as zero when empty.
module ser_fifo
    import ser_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        pop_ok;
    logic        push_ok;

    // One extra pointer bit distinguishes full from empty; level is their difference.
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? EMPTY_BYTE : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ser_rx_fifo.sv
// Buffered 8N1 serial receiver: oversampling bit timer, framing FSM and a
// byte FIFO with sticky frame-error and overrun flags.
module ser_rx_fifo
    import ser_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   bit_len,
    input  logic          read,
    input  logic          clr_err,
    input  logic          serial_in,
    output logic          ready,
    output logic [7:0]    data_out,
    output logic [AW:0]   level,
    output logic          frame_err,
    output logic          overrun
);

    logic        rx_meta;
    logic        rx_s;
    rx_state_e   state;
    rx_state_e   state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_nxt;
    logic [7:0]  shift;
    logic [7:0]  shift_nxt;
    logic        cnt_done;
    logic        push;
    logic        set_ferr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        drop;

    // Line synchroniser: presets to idle so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= LINE_IDLE;
            rx_s    <= LINE_IDLE;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= CNT_ZERO;
            bit_idx <= 3'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_nxt;
    end

    assign cnt_done = (cnt == CNT_ZERO);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        push        = 1'b0;
        set_ferr    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = half_bit_reload(bit_len);
                end
            end
            START: begin
                if (!cnt_done) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (!rx_s) begin
                    state_nxt   = DATA;
                    cnt_nxt     = full_bit_reload(bit_len);
                    bit_idx_nxt = 3'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!cnt_done) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    shift_nxt[bit_idx] = rx_s;
                    cnt_nxt            = full_bit_reload(bit_len);
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (!cnt_done) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (rx_s) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    set_ferr  = 1'b1;
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A held-low line (break) must return high before another start is accepted.
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign drop = push && fifo_full && !(read && !fifo_empty);

    // Sticky flags: a new error in the same cycle as clr_err takes priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (set_ferr)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (drop)         overrun   <= 1'b1;
            else if (clr_err) overrun   <= 1'b0;
        end
    end

    ser_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (read),
        .din   (shift),
        .dout  (data_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign ready = !fifo_empty;

endmodule
